// File: rtl/kmeans_frame_sender.sv
// Host-side frame transmitter for the k-means accelerator: streams centroids plus points
// from a 1-cycle-latency buffer as one gap-free burst, then collects and forwards the 4 results.
module kmeans_frame_sender #(
  parameter int INIT_SIZE      = 4,
  parameter int DATA_SIZE      = 4096,
  parameter int ADDR_W         = 13,
  parameter int TIMEOUT_CYCLES = 16777215
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic              km_in_valid,
  output logic [15:0]       km_in_data,
  input  logic              km_out_valid,
  input  logic [15:0]       km_out_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [15:0]       res_data,
  output logic [1:0]        res_idx
);

  localparam int TOTAL = INIT_SIZE + DATA_SIZE;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  localparam logic [TW-1:0]     TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    FLUSH    = 3'd2,
    WAIT_RES = 3'd3,
    DRAIN    = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] send_cnt;
  logic              rd_pend;   // rd_data carries a valid word this cycle
  logic [1:0]        res_cnt;
  logic [TW-1:0]     tcnt;
  logic [3:0][15:0]  slot;

  // Handshake: a result word moves downstream on every clock edge where res_valid && res_ready;
  // res_data/res_idx are held stable while res_valid=1 and res_ready=0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      send_cnt    <= '0;
      rd_pend     <= 1'b0;
      res_cnt     <= '0;
      tcnt        <= '0;
      slot        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      km_in_valid <= 1'b0;
      km_in_data  <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_idx     <= '0;
    end else if (abort) begin
      // Abort leaves timeout_err and the stored slots alone; everything else goes idle.
      state       <= IDLE;
      send_cnt    <= '0;
      rd_pend     <= 1'b0;
      res_cnt     <= '0;
      tcnt        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      km_in_valid <= 1'b0;
      km_in_data  <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_idx     <= '0;
    end else begin
      done        <= 1'b0;
      // Read pipeline: strobe -> buffer latency -> output register, independent of state.
      rd_pend     <= rd_en;
      km_in_valid <= rd_pend;
      km_in_data  <= rd_pend ? rd_data : 16'h0000;

      case (state)
        IDLE: begin
          // The cycle done is high still belongs to the previous frame.
          if (start && !done) begin
            state       <= SEND;
            busy        <= 1'b1;
            timeout_err <= 1'b0;
            rd_en       <= 1'b1;
            rd_addr     <= '0;
            send_cnt    <= '0;
          end
        end

        SEND: begin
          if (send_cnt == LAST_ADDR) begin
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            send_cnt <= '0;
            state    <= FLUSH;
          end else begin
            send_cnt <= send_cnt + 1'b1;
            rd_addr  <= send_cnt + 1'b1;
          end
        end

        FLUSH: begin
          if (!rd_pend) begin
            state   <= WAIT_RES;
            tcnt    <= '0;
            res_cnt <= '0;
          end
        end

        WAIT_RES: begin
          // Timeout takes priority over a result word arriving in the same cycle.
          if (tcnt == TO_LAST) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            tcnt        <= '0;
            res_cnt     <= '0;
            state       <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (km_out_valid) begin
              slot[res_cnt] <= km_out_data;
              res_cnt       <= res_cnt + 2'd1;
              if (res_cnt == 2'd3) begin
                state     <= DRAIN;
                tcnt      <= '0;
                res_valid <= 1'b1;
                res_idx   <= 2'd0;
                res_data  <= slot[0];
              end
            end
          end
        end

        DRAIN: begin
          if (res_ready) begin
            if (res_idx == 2'd3) begin
              res_valid <= 1'b0;
              res_idx   <= 2'd0;
              res_data  <= '0;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              res_idx  <= res_idx + 2'd1;
              res_data <= slot[res_idx + 2'd1];
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kmeans_frame_sender.sv
// Bench for kmeans_frame_sender: a small-frame instance (DATA_SIZE=8, TIMEOUT_CYCLES=20) for
// protocol scenarios and a full-size instance for the long burst / mid-frame reset scenario.
module tb_kmeans_frame_sender;

  localparam int S_TOTAL = 12;
  localparam int F_TOTAL = 4100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [17:0] res_q[$];

  logic        s_rst_n, s_start, s_abort, s_busy, s_done, s_timeout_err, s_rd_en;
  logic [12:0] s_rd_addr;
  logic [15:0] s_rd_data, s_km_in_data, s_km_out_data, s_res_data;
  logic        s_km_in_valid, s_km_out_valid, s_res_valid, s_res_ready;
  logic [1:0]  s_res_idx;

  logic        f_rst_n, f_start, f_abort, f_busy, f_done, f_timeout_err, f_rd_en;
  logic [12:0] f_rd_addr;
  logic [15:0] f_rd_data, f_km_in_data, f_km_out_data, f_res_data;
  logic        f_km_in_valid, f_km_out_valid, f_res_valid, f_res_ready;
  logic [1:0]  f_res_idx;

  logic [52:0] s_outs, f_outs;
  assign s_outs = {s_busy, s_done, s_timeout_err, s_rd_en, s_rd_addr, s_km_in_valid,
                   s_km_in_data, s_res_valid, s_res_data, s_res_idx};
  assign f_outs = {f_busy, f_done, f_timeout_err, f_rd_en, f_rd_addr, f_km_in_valid,
                   f_km_in_data, f_res_valid, f_res_data, f_res_idx};

  kmeans_frame_sender #(.INIT_SIZE(4), .DATA_SIZE(8), .ADDR_W(13), .TIMEOUT_CYCLES(20)) dut_small (
    .clk(clk), .rst_n(s_rst_n), .start(s_start), .abort(s_abort), .busy(s_busy),
    .done(s_done), .timeout_err(s_timeout_err), .rd_en(s_rd_en), .rd_addr(s_rd_addr),
    .rd_data(s_rd_data), .km_in_valid(s_km_in_valid), .km_in_data(s_km_in_data),
    .km_out_valid(s_km_out_valid), .km_out_data(s_km_out_data), .res_valid(s_res_valid),
    .res_ready(s_res_ready), .res_data(s_res_data), .res_idx(s_res_idx)
  );

  kmeans_frame_sender #(.INIT_SIZE(4), .DATA_SIZE(4096), .ADDR_W(13), .TIMEOUT_CYCLES(16777215)) dut_full (
    .clk(clk), .rst_n(f_rst_n), .start(f_start), .abort(f_abort), .busy(f_busy),
    .done(f_done), .timeout_err(f_timeout_err), .rd_en(f_rd_en), .rd_addr(f_rd_addr),
    .rd_data(f_rd_data), .km_in_valid(f_km_in_valid), .km_in_data(f_km_in_data),
    .km_out_valid(f_km_out_valid), .km_out_data(f_km_out_data), .res_valid(f_res_valid),
    .res_ready(f_res_ready), .res_data(f_res_data), .res_idx(f_res_idx)
  );

  // Point buffers: address n holds 16'h0100+n, one cycle read latency.
  always @(posedge clk) begin
    s_rd_data <= s_rd_en ? 16'h0100 + 16'(s_rd_addr) : 16'h0000;
    f_rd_data <= f_rd_en ? 16'h0100 + 16'(f_rd_addr) : 16'h0000;
  end

  task automatic test_reset();
    s_rst_n = 1'b0; s_start = 1'b0; s_abort = 1'b0; s_km_out_valid = 1'b0;
    s_km_out_data = 16'h0; s_res_ready = 1'b0;
    f_rst_n = 1'b0; f_start = 1'b0; f_abort = 1'b0; f_km_out_valid = 1'b0;
    f_km_out_data = 16'h0; f_res_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (s_outs !== '0) begin errors++; $display("FAIL reset_small: got %h exp 0", s_outs); end
    checks++;
    if (f_outs !== '0) begin errors++; $display("FAIL reset_full: got %h exp 0", f_outs); end
    s_rst_n = 1'b1; f_rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (s_outs !== '0) begin errors++; $display("FAIL idle_small: got %h exp 0", s_outs); end
    checks++;
    if (f_outs !== '0) begin errors++; $display("FAIL idle_full: got %h exp 0", f_outs); end
  endtask

  // Exact cycle timing of the first frame; leaves the small DUT waiting for results.
  task automatic test_burst_timing();
    logic [15:0] w;
    logic        exp_rd, exp_kv;
    exp_q.delete();
    for (int n = 0; n < S_TOTAL; n++) exp_q.push_back(16'h0100 + 16'(n));
    s_start = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      s_start = 1'b0;
      exp_rd = (cyc >= 1 && cyc <= 12);
      exp_kv = (cyc >= 3 && cyc <= 14);
      checks++;
      if (s_rd_en !== exp_rd) begin errors++; $display("FAIL rd_en_c%0d: got %b exp %b", cyc, s_rd_en, exp_rd); end
      if (exp_rd) begin
        checks++;
        if (s_rd_addr !== 13'(cyc - 1)) begin errors++; $display("FAIL rd_addr_c%0d: got %0d exp %0d", cyc, s_rd_addr, cyc - 1); end
      end
      checks++;
      if (s_km_in_valid !== exp_kv) begin errors++; $display("FAIL in_valid_c%0d: got %b exp %b", cyc, s_km_in_valid, exp_kv); end
      if (s_km_in_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL in_data_c%0d: got %h exp none", cyc, s_km_in_data); end
        else begin
          w = exp_q.pop_front();
          if (s_km_in_data !== w) begin errors++; $display("FAIL in_data_c%0d: got %h exp %h", cyc, s_km_in_data, w); end
        end
      end else begin
        checks++;
        if (s_km_in_data !== 16'h0) begin errors++; $display("FAIL in_data_idle_c%0d: got %h exp 0", cyc, s_km_in_data); end
      end
      if (cyc == 1) begin
        checks++;
        if (s_busy !== 1'b1) begin errors++; $display("FAIL busy_c1: got %b exp 1", s_busy); end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL burst_words_left: got %0d exp 0", exp_q.size()); end
    exp_q.delete();
  endtask

  // Sends one frame on the small DUT; returns on the first cycle km_in_valid is low after the burst.
  task automatic send_frame_s(input bit poke);
    int          got;
    logic [15:0] w;
    got = 0;
    exp_q.delete();
    for (int n = 0; n < S_TOTAL; n++) exp_q.push_back(16'h0100 + 16'(n));
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    checks++;
    if ({s_busy, s_timeout_err} !== 2'b10) begin
      errors++; $display("FAIL frame_start: busy,timeout_err got %b exp 10", {s_busy, s_timeout_err});
    end
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (s_km_in_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL frame_data: got %h exp none", s_km_in_data); end
        else begin
          w = exp_q.pop_front();
          if (s_km_in_data !== w) begin errors++; $display("FAIL frame_data: got %h exp %h", s_km_in_data, w); end
        end
        got++;
        s_start = poke && (got == 3);
      end else if (got > 0) begin
        break;
      end
    end
    s_start = 1'b0;
    checks++;
    if (got != S_TOTAL) begin errors++; $display("FAIL frame_len: got %0d exp %0d", got, S_TOTAL); end
    exp_q.delete();
  endtask

  task automatic drive_results_s(input int n, input int gap_after);
    for (int i = 0; i < n; i++) begin
      if (i == gap_after) begin
        s_km_out_valid = 1'b0;
        repeat (2) @(negedge clk);
      end
      s_km_out_valid = 1'b1;
      s_km_out_data  = 16'h1111 * 16'(i + 1);
      res_q.push_back({2'(i), s_km_out_data});
      @(negedge clk);
    end
    s_km_out_valid = 1'b0;
    s_km_out_data  = 16'h0;
  endtask

  task automatic test_done_path();
    int xfers, done_cnt, first, start_cyc;
    logic [17:0] e;
    xfers = 0; done_cnt = 0; first = -1; start_cyc = -1;
    res_q.delete();
    drive_results_s(4, 2);
    s_res_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (start_cyc >= 0 && cyc == start_cyc + 1) begin
        s_start = 1'b0;
        checks++;
        if (s_busy !== 1'b0) begin errors++; $display("FAIL start_on_done: busy got %b exp 0", s_busy); end
      end
      if (s_done === 1'b1) begin
        done_cnt++;
        checks++;
        if (xfers != 4 || s_res_valid !== 1'b0) begin
          errors++; $display("FAIL done_timing: xfers got %0d exp 4, res_valid got %b exp 0", xfers, s_res_valid);
        end
        s_start = 1'b1;
        start_cyc = cyc;
      end
      if (s_res_valid === 1'b1) begin
        checks++;
        if (res_q.size() == 0) begin errors++; $display("FAIL res_word: got %h exp none", {s_res_idx, s_res_data}); end
        else begin
          e = res_q.pop_front();
          if ({s_res_idx, s_res_data} !== e) begin errors++; $display("FAIL res_word: got %h exp %h", {s_res_idx, s_res_data}, e); end
        end
        if (first < 0) first = cyc;
        checks++;
        if (cyc != first + xfers) begin errors++; $display("FAIL back_to_back: cycle got %0d exp %0d", cyc, first + xfers); end
        xfers++;
      end
      @(negedge clk);
    end
    s_res_ready = 1'b0;
    s_start = 1'b0;
    checks++;
    if (xfers != 4 || done_cnt != 1) begin errors++; $display("FAIL done_path_count: xfers %0d done %0d exp 4 1", xfers, done_cnt); end
    res_q.delete();
  endtask

  task automatic test_ready_stall();
    int xfers, done_cnt;
    logic [6:0] pat;
    logic r;
    xfers = 0; done_cnt = 0;
    pat = 7'b1101001;
    send_frame_s(1'b0);
    res_q.delete();
    drive_results_s(4, 4);
    for (int cyc = 0; cyc < 12; cyc++) begin
      r = (cyc < 7) ? pat[cyc] : 1'b0;
      if (s_done === 1'b1) done_cnt++;
      if (s_res_valid === 1'b1) begin
        checks++;
        if (res_q.size() == 0) begin errors++; $display("FAIL stall_dup: got %h exp none", {s_res_idx, s_res_data}); end
        else if ({s_res_idx, s_res_data} !== res_q[0]) begin
          errors++; $display("FAIL stall_word: got %h exp %h", {s_res_idx, s_res_data}, res_q[0]);
        end
        if (r) begin
          if (res_q.size() > 0) void'(res_q.pop_front());
          xfers++;
        end
      end
      s_res_ready = r;
      @(negedge clk);
    end
    s_res_ready = 1'b0;
    checks++;
    if (xfers != 4 || done_cnt != 1 || res_q.size() != 0) begin
      errors++; $display("FAIL stall_count: xfers %0d done %0d left %0d exp 4 1 0", xfers, done_cnt, res_q.size());
    end
    res_q.delete();
  endtask

  task automatic test_timeout();
    logic exp_to;
    send_frame_s(1'b0);
    for (int j = 0; j <= 22; j++) begin
      exp_to = (j >= 20);
      checks++;
      if ({s_timeout_err, s_res_valid} !== {exp_to, 1'b0}) begin
        errors++; $display("FAIL timeout_j%0d: timeout_err,res_valid got %b exp %b0", j, {s_timeout_err, s_res_valid}, exp_to);
      end
      if (j == 20) begin
        checks++;
        if (s_busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: busy got %b exp 0", s_busy); end
      end
      s_km_out_valid = (j < 3);
      s_km_out_data  = 16'hA000 + 16'(j);
      @(negedge clk);
    end
    s_km_out_valid = 1'b0;
    s_km_out_data  = 16'h0;
    s_abort = 1'b1;
    @(negedge clk);
    s_abort = 1'b0;
    checks++;
    if ({s_timeout_err, s_busy} !== 2'b10) begin
      errors++; $display("FAIL abort_keeps_err: timeout_err,busy got %b exp 10", {s_timeout_err, s_busy});
    end
  endtask

  task automatic test_ignored_start();
    int xfers, done_cnt;
    logic r;
    xfers = 0; done_cnt = 0;
    send_frame_s(1'b1);
    res_q.delete();
    drive_results_s(4, 4);
    for (int cyc = 0; cyc < 24; cyc++) begin
      r = (cyc >= 3);
      s_start = (cyc == 1);
      if (s_done === 1'b1) done_cnt++;
      if (s_res_valid === 1'b1) begin
        checks++;
        if (res_q.size() == 0) begin errors++; $display("FAIL ign_word: got %h exp none", {s_res_idx, s_res_data}); end
        else if ({s_res_idx, s_res_data} !== res_q[0]) begin
          errors++; $display("FAIL ign_word: got %h exp %h", {s_res_idx, s_res_data}, res_q[0]);
        end
        if (r) begin
          if (res_q.size() > 0) void'(res_q.pop_front());
          xfers++;
        end
      end
      checks++;
      if ({s_km_in_valid, s_rd_en} !== 2'b00) begin
        errors++; $display("FAIL second_frame: km_in_valid,rd_en got %b exp 00", {s_km_in_valid, s_rd_en});
      end
      if (cyc >= 8) begin
        checks++;
        if (s_busy !== 1'b0) begin errors++; $display("FAIL ign_busy_c%0d: got %b exp 0", cyc, s_busy); end
      end
      s_res_ready = r;
      @(negedge clk);
    end
    s_start = 1'b0;
    s_res_ready = 1'b0;
    checks++;
    if (xfers != 4 || done_cnt != 1) begin errors++; $display("FAIL ign_count: xfers %0d done %0d exp 4 1", xfers, done_cnt); end
    res_q.delete();
  endtask

  task automatic test_abort();
    int got;
    logic [15:0] w;
    got = 0;
    exp_q.delete();
    for (int n = 0; n < S_TOTAL; n++) exp_q.push_back(16'h0100 + 16'(n));
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (s_km_in_valid === 1'b1) begin
        checks++;
        w = exp_q.pop_front();
        if (s_km_in_data !== w) begin errors++; $display("FAIL abort_data: got %h exp %h", s_km_in_data, w); end
        got++;
        if (got == 5) begin
          s_abort = 1'b1;
          @(negedge clk);
          s_abort = 1'b0;
          checks++;
          if ({s_km_in_valid, s_busy, s_rd_en, s_res_valid} !== 4'b0000) begin
            errors++; $display("FAIL abort_stop: valid,busy,rd_en,res_valid got %b exp 0000", {s_km_in_valid, s_busy, s_rd_en, s_res_valid});
          end
          break;
        end
      end
    end
    checks++;
    if (got != 5) begin errors++; $display("FAIL abort_reach: words got %0d exp 5", got); end
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      checks++;
      if ({s_done, s_km_in_valid, s_busy, s_timeout_err} !== 4'b0000) begin
        errors++; $display("FAIL abort_after_c%0d: done,valid,busy,err got %b exp 0000", cyc, {s_done, s_km_in_valid, s_busy, s_timeout_err});
      end
    end
    exp_q.delete();
  endtask

  task automatic test_full_reset();
    int got;
    logic [15:0] w;
    got = 0;
    f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    repeat (100) @(negedge clk);
    checks++;
    if (f_rd_en !== 1'b1 || f_km_in_valid !== 1'b1) begin
      errors++; $display("FAIL full_mid_send: rd_en,valid got %b exp 11", {f_rd_en, f_km_in_valid});
    end
    f_rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (f_outs !== '0) begin errors++; $display("FAIL full_reset: got %h exp 0", f_outs); end
    f_rst_n = 1'b1;
    @(negedge clk);
    exp_q.delete();
    for (int n = 0; n < F_TOTAL; n++) exp_q.push_back(16'h0100 + 16'(n));
    f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    for (int cyc = 0; cyc < 4200; cyc++) begin
      @(negedge clk);
      if (f_km_in_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL full_data: got %h exp none", f_km_in_data); end
        else begin
          w = exp_q.pop_front();
          if (f_km_in_data !== w) begin errors++; $display("FAIL full_data: got %h exp %h", f_km_in_data, w); end
        end
        got++;
      end else if (got > 0) begin
        break;
      end
    end
    checks++;
    if (got != F_TOTAL) begin errors++; $display("FAIL full_len: got %0d exp %0d", got, F_TOTAL); end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_burst_timing();
    test_done_path();
    test_ready_stall();
    test_timeout();
    test_ignored_start();
    test_abort();
    test_full_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: sim time got %0t exp below 1000000", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/kmeans_frame_sender.md
Name: kmeans_frame_sender

Overview:
- Host-side transmitter for the k-means accelerator stream interface.
- On `start`, reads one frame from a point buffer through a 1-cycle-latency read port: INIT_SIZE initial centroids, then DATA_SIZE data points.
- Drives the frame to the accelerator as one gap-free in_valid burst, then waits for the 4-word out_valid result burst.
- Buffers the result and hands it downstream over a valid/ready stream.

Parameters:
- INIT_SIZE, 4, number of initial centroid words sent first; fixed at 4 for the current accelerator.
- DATA_SIZE, 4096, number of data-point words sent after the centroids.
- ADDR_W, 13, point-buffer address width; must satisfy 2^ADDR_W >= INIT_SIZE+DATA_SIZE.
- TIMEOUT_CYCLES, 16777215, maximum cycles allowed in the wait for all 4 result words.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  frame request; sampled only in IDLE
- abort  in  1  synchronous abort; returns the block to IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the 4th result word is accepted
- timeout_err  out  1  sticky; cleared by the next accepted start
- rd_en  out  1  point-buffer read strobe
- rd_addr  out  ADDR_W  point-buffer read address
- rd_data  in  16  read data, valid the cycle after rd_en; [15:8]=x, [7:0]=y
- km_in_valid  out  1  accelerator in_valid
- km_in_data  out  16  accelerator in_data
- km_out_valid  in  1  accelerator out_valid
- km_out_data  in  16  accelerator out_data (centroid, x in [15:8])
- res_valid  out  1  result word available
- res_ready  in  1  downstream accepts the result word
- res_data  out  16  result centroid word
- res_idx  out  2  centroid index of res_data, 0..3

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; all counters 0; result registers 0.
- All outputs are registered; TOTAL = INIT_SIZE+DATA_SIZE.
- States: IDLE, SEND, FLUSH, WAIT_RES, DRAIN.
- IDLE:
  - start=1 at edge T: state goes to SEND, timeout_err clears, busy=1 from T+1.
  - start while busy is ignored.
- SEND:
  - rd_en=1 for exactly TOTAL consecutive cycles T+1..T+TOTAL.
  - rd_addr steps 0,1,...,TOTAL-1, one per cycle.
  - Each rd_data word is registered onto km_in_data with km_in_valid=1.
  - Words appear on cycles T+3..T+TOTAL+2 in address order, with no bubble.
  - After the last read issues, the state goes to FLUSH.
- FLUSH:
  - Lasts until the last word has been driven.
  - km_in_valid=0 and km_in_data=0 from cycle T+TOTAL+3.
  - Then the state goes to WAIT_RES.
- km_in_valid is never high outside a frame burst.
  - Frame boundary for the accelerator = first km_in_valid rise.
  - End of data = first low after the burst.
- WAIT_RES:
  - The timeout counter starts at 0 on entry and increments every cycle.
  - Each cycle with km_out_valid=1 stores km_out_data into result slot res_cnt; res_cnt increments.
  - Gaps between result words are tolerated.
  - When the 4th word is stored, the state goes to DRAIN and the counter is cleared.
  - If the counter reaches TIMEOUT_CYCLES before 4 words are stored: timeout_err=1, state returns to IDLE, done stays 0, no res_valid.
- km_out_valid outside WAIT_RES is ignored; no slot is written.
- km_out_valid in the same cycle the timeout fires: the timeout wins.
- DRAIN:
  - res_valid=1 with res_data=slot[k] and res_idx=k, for k=0..3.
  - k advances on each res_valid&&res_ready cycle.
  - res_data and res_idx hold stable while res_ready=0.
  - Back-to-back acceptance delivers one word per cycle.
  - On the 4th acceptance: done pulses 1 cycle, res_valid drops on the next cycle, state returns to IDLE.
  - start in the same cycle as done is ignored; it is honoured from the next cycle.
- abort=1 in any state:
  - Next cycle: IDLE, km_in_valid=0, rd_en=0, res_valid=0, counters cleared, no done.
  - timeout_err is unchanged.
  - A mid-SEND abort truncates the frame; system software must reset the accelerator before the next start.
- abort wins over start, timeout and handshake in the same cycle.
- rst_n=0 mid-operation: every register returns to its reset value at the next edge, including km_in_valid=0.
- Counter widths:
  - Send counter: ADDR_W bits; terminal value TOTAL-1, no wrap.
  - res_cnt and k: 2 bits.
  - Timeout counter: clog2(TIMEOUT_CYCLES+1) bits.

Test Plan:
1. DATA_SIZE=8; buffer addr n holds 16'h0100+n; start at edge 0 -> km_in_valid high on cycles 3..14 with data 0100..010B in order; low from cycle 15; rd_en high on cycles 1..12 only.
2. After the burst, model returns 4 out_valid words 1111,2222,3333,4444 with a 2-cycle gap after the 2nd; res_ready=1 -> res sequence (idx0,1111)..(idx3,4444) on consecutive cycles; done pulses on the 4th acceptance.
3. res_ready toggled 1,0,0,1,0,1,1 during DRAIN -> exactly 4 transfers; res_data and res_idx stable through stalls; no duplicates or drops.
4. TIMEOUT_CYCLES=20, model returns only 3 words -> timeout_err=1 on the 20th WAIT_RES cycle; back to IDLE; no res_valid; next start clears timeout_err.
5. start pulsed during SEND and DRAIN -> ignored, one frame only; abort on the 5th km_in_valid cycle -> km_in_valid=0 next cycle, busy=0, done never pulses.
6. Full DATA_SIZE=4096 with rst_n asserted mid-SEND -> all outputs 0 next edge; a fresh start resends from addr 0 with a 4100-cycle gap-free burst.
